// File: rtl/epcs_responder.sv
`default_nettype none
// ============================================================================
// Module   : epcs_responder
// Brief    : EPCS-style serial flash slave: read (0x03), status (0x05) and
//            silicon-ID (0xAB), with a one-byte prefetch from backing memory.
// Revision : 1.0 - initial release
// ============================================================================
module epcs_responder #(
    parameter int         ADDR_W      = 24,
    parameter logic [7:0] SILICON_ID  = 8'h12,
    parameter int         MEM_LAT_MAX = 8
) (
    input  logic              SYS_CLK,
    input  logic              SIM_RST,
    input  logic              EPCS_CSN,
    input  logic              EPCS_DCLK,
    input  logic              EPCS_ASDI,
    output logic              EPCS_DATA,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    output logic              busy,
    output logic              underrun
);

    localparam int                  c_WAIT_W = $clog2(MEM_LAT_MAX + 1);
    localparam logic [c_WAIT_W-1:0] c_LAT    = c_WAIT_W'(MEM_LAT_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_DATA   = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_csn_s, r_dclk_s, r_asdi_s;
    logic                r_csn_d, r_dclk_d;
    logic [4:0]          r_bit_cnt;
    logic [23:0]         r_shift_in;
    logic [7:0]          r_shift_out;
    logic                r_data_out;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_mem_rd, r_underrun;
    logic                r_pending, r_held, r_mode_mem;
    logic [c_WAIT_W-1:0] r_wait;
    logic [7:0]          r_held_data, r_const_byte;
    logic [1:0]          r_stale;

    logic        w_csn, w_asdi, w_csn_fall, w_dclk_rise, w_dclk_fall;
    logic [23:0] w_shift_in_nxt;
    logic        w_cnt_clr, w_cnt_inc, w_start_fetch, w_enter_const;
    logic [7:0]  w_const_val;
    logic        w_load, w_shift, w_abort;
    logic        w_accept, w_drop, w_timeout, w_mem_load, w_new_rd;
    logic        w_underrun_evt, w_abandon;
    logic [7:0]  w_load_byte;

    always_ff @(posedge SYS_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_csn_s  <= 2'b11;
            r_dclk_s <= 2'b00;
            r_asdi_s <= 2'b00;
            r_csn_d  <= 1'b1;
            r_dclk_d <= 1'b0;
        end else begin
            r_csn_s  <= {r_csn_s[0], EPCS_CSN};
            r_dclk_s <= {r_dclk_s[0], EPCS_DCLK};
            r_asdi_s <= {r_asdi_s[0], EPCS_ASDI};
            r_csn_d  <= r_csn_s[1];
            r_dclk_d <= r_dclk_s[1];
        end
    end

    assign w_csn          = r_csn_s[1];
    assign w_asdi         = r_asdi_s[1];
    assign w_csn_fall     = ~w_csn & r_csn_d;
    assign w_dclk_rise    = r_dclk_s[1] & ~r_dclk_d;
    assign w_dclk_fall    = ~r_dclk_s[1] & r_dclk_d;
    assign w_shift_in_nxt = {r_shift_in[22:0], w_asdi};

    // Deasserted chip select takes priority over any DCLK edge in the same cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_start_fetch = 1'b0;
        w_enter_const = 1'b0;
        w_const_val   = 8'h00;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        w_abort       = 1'b0;
        if (r_state != S_IDLE && w_csn) begin
            w_state_nxt = S_IDLE;
            w_abort     = 1'b1;
            w_cnt_clr   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_csn_fall) begin
                        w_state_nxt = S_CMD;
                        w_cnt_clr   = 1'b1;
                    end
                end
                S_CMD: begin
                    if (w_dclk_rise) begin
                        if (r_bit_cnt == 5'd7) begin
                            w_cnt_clr = 1'b1;
                            case (w_shift_in_nxt[7:0])
                                8'h03: w_state_nxt = S_ADDR;
                                8'h05: begin
                                    w_state_nxt   = S_DATA;
                                    w_enter_const = 1'b1;
                                end
                                8'hAB:   w_state_nxt = S_DUMMY;
                                default: w_state_nxt = S_IGNORE;
                            endcase
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_dclk_rise) begin
                        if (r_bit_cnt == 5'd23) begin
                            w_state_nxt   = S_DATA;
                            w_start_fetch = 1'b1;
                            w_cnt_clr     = 1'b1;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                S_DUMMY: begin
                    if (w_dclk_rise) begin
                        if (r_bit_cnt == 5'd23) begin
                            w_state_nxt   = S_DATA;
                            w_enter_const = 1'b1;
                            w_const_val   = SILICON_ID;
                            w_cnt_clr     = 1'b1;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_dclk_fall) begin
                        w_cnt_inc = 1'b1;
                        if (r_bit_cnt[2:0] == 3'd0) begin
                            w_load = 1'b1;
                        end else begin
                            w_shift = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A fetch abandoned by timeout or underrun may still return; r_stale
    // counts such returns so they are dropped instead of mistaken for the next byte.
    assign w_accept       = mem_valid & r_pending & (r_stale == 2'd0);
    assign w_drop         = mem_valid & (r_stale != 2'd0);
    assign w_timeout      = r_pending & (r_wait == c_LAT) & ~w_accept;
    assign w_mem_load     = w_load & r_mode_mem;
    assign w_new_rd       = w_start_fetch | w_mem_load;
    assign w_underrun_evt = w_mem_load & ~r_held & ~w_accept;
    assign w_abandon      = r_pending & ~w_accept & (w_timeout | w_underrun_evt);

    always_comb begin
        w_load_byte = r_const_byte;
        if (r_mode_mem) begin
            if (r_held) begin
                w_load_byte = r_held_data;
            end else if (w_accept) begin
                w_load_byte = mem_data;
            end else begin
                w_load_byte = 8'hFF;
            end
        end
    end

    always_ff @(posedge SYS_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift_in   <= '0;
            r_shift_out  <= 8'hFF;
            r_data_out   <= 1'b1;
            r_addr       <= '0;
            r_mem_rd     <= 1'b0;
            r_underrun   <= 1'b0;
            r_pending    <= 1'b0;
            r_wait       <= '0;
            r_held       <= 1'b0;
            r_held_data  <= '0;
            r_stale      <= '0;
            r_mode_mem   <= 1'b0;
            r_const_byte <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_rd   <= 1'b0;
            r_underrun <= 1'b0;
            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (w_dclk_rise) begin
                r_shift_in <= w_shift_in_nxt;
            end
            if (w_abort) begin
                r_data_out <= 1'b1;
                r_pending  <= 1'b0;
                r_held     <= 1'b0;
                r_stale    <= '0;
            end else begin
                if (w_enter_const) begin
                    r_mode_mem   <= 1'b0;
                    r_const_byte <= w_const_val;
                end
                if (w_start_fetch) begin
                    r_mode_mem <= 1'b1;
                    r_addr     <= w_shift_in_nxt[ADDR_W-1:0];
                end else if (w_mem_load) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
                if (w_new_rd) begin
                    r_mem_rd  <= 1'b1;
                    r_pending <= 1'b1;
                    r_wait    <= '0;
                end else begin
                    if (w_accept | w_abandon) begin
                        r_pending <= 1'b0;
                    end
                    if (r_pending && r_wait != c_LAT) begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
                end
                if (w_new_rd) begin
                    r_held <= 1'b0;
                end else if (w_accept) begin
                    r_held      <= 1'b1;
                    r_held_data <= mem_data;
                end
                if (w_abandon && !w_drop && r_stale != 2'd3) begin
                    r_stale <= r_stale + 2'd1;
                end else if (w_drop && !w_abandon) begin
                    r_stale <= r_stale - 2'd1;
                end
                r_underrun <= w_underrun_evt;
                if (w_load) begin
                    r_data_out  <= w_load_byte[7];
                    r_shift_out <= {w_load_byte[6:0], 1'b0};
                end else if (w_shift) begin
                    r_data_out  <= r_shift_out[7];
                    r_shift_out <= {r_shift_out[6:0], 1'b0};
                end
            end
        end
    end

    assign EPCS_DATA = r_data_out;
    assign mem_addr  = r_addr;
    assign mem_rd    = r_mem_rd;
    assign busy      = ~w_csn;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire
